// File: rtl/fxp_op_initiator.sv
// Initiator for the fixed-point arithmetic unit. It takes one request at a time, drives the unit's
// operand/opcode/start lines, waits a fixed time (add/mul) or for complete (div), then returns the result.
module fxp_op_initiator #(
  parameter int WIDTH       = 32,
  parameter int ADDMUL_WAIT = 2,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  input  logic [1:0]       req_op_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             rsp_err_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [1:0]       alu_opcode_o,
  output logic             alu_start_o,
  input  logic [WIDTH-1:0] alu_c_i,
  input  logic             alu_complete_i
);

  localparam int MAXC = (ADDMUL_WAIT > DIV_TIMEOUT) ? ADDMUL_WAIT : DIV_TIMEOUT;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] AM_LAST  = CW'(ADDMUL_WAIT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_TIMEOUT - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [1:0]       alu_op_q;
  logic             alu_start_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= OP_ADD;
      alu_start_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      alu_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            alu_a_q     <= req_a_i;
            alu_b_q     <= req_b_i;
            alu_op_q    <= req_op_i;
            req_ready_q <= 1'b0;
            if (req_op_i == OP_ILL) begin
              // Illegal opcode never reaches the unit; answer with an error at once.
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q     <= S_ISSUE;
              alu_start_q <= (req_op_i == OP_DIV);
            end
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // Complete is looked at only here, so a level left from an earlier div is ignored in ISSUE.
          if (alu_op_q == OP_DIV) begin
            if (alu_complete_i) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= alu_c_i;
              rsp_err_q   <= 1'b0;
            end else if (cnt_q == DIV_LAST) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
            end
          end else if (cnt_q == AM_LAST) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= alu_c_i;
            rsp_err_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_err_o    = rsp_err_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_opcode_o = alu_op_q;
  assign alu_start_o  = alu_start_q;

endmodule

// File: tb/tb_fxp_op_initiator.sv
// Bench for fxp_op_initiator: stub arithmetic unit, directed spec cases plus randomized ops
// checked against a latency/result model derived from the protocol rules.
module tb_fxp_op_initiator;
  localparam int W  = 32;
  localparam int AW = 2;
  localparam int TO = 64;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [W-1:0]  req_a_i = '0;
  logic [W-1:0]  req_b_i = '0;
  logic [1:0]    req_op_i = 2'b00;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [W-1:0]  rsp_data_o;
  logic          rsp_err_o;
  logic [W-1:0]  alu_a_o;
  logic [W-1:0]  alu_b_o;
  logic [1:0]    alu_opcode_o;
  logic          alu_start_o;
  logic [W-1:0]  alu_c_i;
  logic          alu_complete_i;

  int checks = 0;
  int failures = 0;

  fxp_op_initiator #(.WIDTH(W), .ADDMUL_WAIT(AW), .DIV_TIMEOUT(TO)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_op_i(req_op_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_opcode_o(alu_opcode_o),
    .alu_start_o(alu_start_o), .alu_c_i(alu_c_i), .alu_complete_i(alu_complete_i)
  );

  always #5 clk_i = ~clk_i;

  // Stub unit: add/mul are combinational, div raises complete stub_dly cycles after seeing start.
  int           stub_dly = 0;
  logic [W-1:0] stub_div_c = '0;
  logic         stub_complete = 1'b0;
  logic         stub_armed = 1'b0;
  int           stub_cnt = 0;

  function automatic logic [W-1:0] mulf(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return p[47:16];
  endfunction

  always @(posedge clk_i) begin
    if (reset_i) begin
      stub_armed    <= 1'b0;
      stub_complete <= 1'b0;
    end else if (alu_start_o) begin
      stub_complete <= 1'b0;
      stub_armed    <= (stub_dly != 0);
      stub_cnt      <= stub_dly;
    end else if (stub_armed) begin
      if (stub_cnt == 1) begin
        stub_complete <= 1'b1;
        stub_armed    <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  assign alu_complete_i = stub_complete;
  assign alu_c_i = (alu_opcode_o == 2'b00) ? alu_a_o + alu_b_o :
                   (alu_opcode_o == 2'b01) ? mulf(alu_a_o, alu_b_o) :
                   stub_complete ? stub_div_c : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One full transaction from IDLE; hold = cycles of response backpressure with a queued request.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        input int dly, input logic [W-1:0] divc, input int hold);
    int exp_lat;
    logic [W-1:0] exp_data;
    logic exp_err;
    int lat;
    int starts;
    bit held_ok;
    bit stable_ok;
    logic [W-1:0] d0;
    logic e0;

    stub_dly   = dly;
    stub_div_c = divc;
    case (op)
      2'b00: begin exp_lat = AW + 1; exp_data = a + b;       exp_err = 1'b0; end
      2'b01: begin exp_lat = AW + 1; exp_data = mulf(a, b);  exp_err = 1'b0; end
      2'b10: begin
        if (dly != 0 && dly <= TO - 1) begin
          exp_lat = dly + 2; exp_data = divc; exp_err = 1'b0;
        end else begin
          exp_lat = TO + 1;  exp_data = '0;   exp_err = 1'b1;
        end
      end
      default: begin exp_lat = 0; exp_data = '0; exp_err = 1'b1; end
    endcase

    chk("req_ready_idle", req_ready_o, 1'b1);
    req_a_i = a; req_b_i = b; req_op_i = op; req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;

    lat = 0; starts = 0; held_ok = 1'b1;
    while (1) begin
      if (alu_start_o) starts++;
      if (alu_a_o !== a || alu_b_o !== b || alu_opcode_o !== op) held_ok = 1'b0;
      if (rsp_valid_o || lat > TO + 20) break;
      step();
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("rsp_data", rsp_data_o, exp_data);
    chk("rsp_err", rsp_err_o, exp_err);
    chk("start_pulses", starts, (op == 2'b10) ? 1 : 0);
    chk("alu_held", held_ok, 1'b1);
    chk("req_ready_busy", req_ready_o, 1'b0);

    if (hold > 0) begin
      d0 = rsp_data_o; e0 = rsp_err_o; stable_ok = 1'b1;
      req_a_i = ~a; req_b_i = ~b; req_op_i = 2'b00; req_valid_i = 1'b1;
      for (int i = 0; i < hold; i++) begin
        step();
        if (rsp_valid_o !== 1'b1 || rsp_data_o !== d0 || rsp_err_o !== e0 ||
            req_ready_o !== 1'b0 || alu_a_o !== a) stable_ok = 1'b0;
      end
      chk("backpressure_stable", stable_ok, 1'b1);
    end

    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    chk("rsp_valid_after_hs", rsp_valid_o, 1'b0);
    chk("req_ready_after_hs", req_ready_o, 1'b1);
    chk("no_early_accept", alu_a_o, a);
  endtask

  initial begin
    logic [1:0] op;
    int dly;
    int r;

    step();
    chk("rst_req_ready", req_ready_o, 1'b1);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_rsp_data", rsp_data_o, '0);
    chk("rst_rsp_err", rsp_err_o, 1'b0);
    chk("rst_alu_a", alu_a_o, '0);
    chk("rst_alu_b", alu_b_o, '0);
    chk("rst_alu_op", alu_opcode_o, 2'b00);
    chk("rst_alu_start", alu_start_o, 1'b0);
    reset_i = 1'b0;
    step();

    run_op(32'h00C0_0000, 32'h0100_0000, 2'b00, 0, '0, 0);
    chk("add_result", rsp_data_o, 32'h01C0_0000);
    run_op(32'h00C0_0000, 32'h0002_0000, 2'b01, 0, '0, 0);
    chk("mul_result", rsp_data_o, 32'h0180_0000);
    run_op(32'h0003_0000, 32'h0001_0000, 2'b10, 20, 32'h0001_8000, 0);
    chk("div_result", rsp_data_o, 32'h0001_8000);
    run_op(32'h0003_0000, 32'h0001_0000, 2'b10, 0, 32'h1234_5678, 0);
    run_op(32'h1111_1111, 32'h2222_2222, 2'b11, 0, '0, 0);
    run_op(32'h0000_0005, 32'h0000_0007, 2'b00, 0, '0, 5);
    run_op(32'h0005_0000, 32'h0002_0000, 2'b10, TO - 1, 32'h0002_8000, 0);
    run_op(32'h0005_0000, 32'h0002_0000, 2'b10, TO, 32'h0002_8000, 0);
    run_op(32'h0007_0000, 32'h0003_0000, 2'b10, 1, 32'hCAFE_0001, 3);

    // Reset while a div sits in WAIT.
    stub_dly = 0;
    req_a_i = 32'h0009_0000; req_b_i = 32'h0003_0000; req_op_i = 2'b10; req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    repeat (10) step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("midrst_req_ready", req_ready_o, 1'b1);
    chk("midrst_rsp_valid", rsp_valid_o, 1'b0);
    chk("midrst_alu_start", alu_start_o, 1'b0);
    chk("midrst_alu_a", alu_a_o, '0);
    step();
    chk("midrst_no_rsp", rsp_valid_o, 1'b0);
    run_op(32'h0001_0000, 32'h0002_0000, 2'b00, 0, '0, 0);

    for (int n = 0; n < 30; n++) begin
      op = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      dly = (r == 0) ? 0 : (r == 1) ? TO - 1 : (r == 2) ? TO : $urandom_range(1, 30);
      run_op($urandom, $urandom, op, dly, $urandom, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
